// File: rtl/ssd_scan_ctrl.sv
// Multiplexed N-digit seven-segment scan controller with double-buffered
// frame data, per-digit blink, PWM brightness and tear-free frame updates.
module ssd_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 18,
  parameter int unsigned BRIGHT_W     = 4,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    board_clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned HEX_W = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]  LAST_FRAME = FC_W'(BLINK_FRAMES - 1);

  logic [SCAN_DIV-1:0]   prescaler;
  logic [IDX_W-1:0]      idx;
  logic [FC_W-1:0]       frame_cnt;
  logic                  blink_phase;
  logic                  pending;

  logic [HEX_W-1:0]      stg_hex;
  logic [NUM_DIGITS-1:0] stg_dp;
  logic [NUM_DIGITS-1:0] stg_en;
  logic [NUM_DIGITS-1:0] stg_blink;

  logic [HEX_W-1:0]      disp_hex;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] disp_en;
  logic [NUM_DIGITS-1:0] disp_blink;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic                  transfer;
  logic                  pwm_on;
  logic                  lit;
  logic [3:0]            cur_hex;
  logic                  cur_dp;
  logic                  cur_en;
  logic                  cur_blink;

  // Active-low hex to segment {CA..CG} decode.
  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // A load on the boundary edge itself defers the transfer to the next frame.
  assign slot_wrap  = &prescaler;
  assign frame_wrap = slot_wrap && (idx == LAST_IDX);
  assign transfer   = frame_wrap && pending && !load;
  assign pwm_on     = prescaler[SCAN_DIV-1 -: BRIGHT_W] < brightness;

  // Select the currently scanned digit from the display buffer.
  always_comb begin
    cur_hex   = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blink = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_hex   = disp_hex[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_en    = disp_en[i];
        cur_blink = disp_blink[i];
      end
    end
  end

  assign lit = cur_en && !(cur_blink && blink_phase) && pwm_on;

  // Scan timebase: prescaler, digit index, frame counter and blink phase.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      prescaler <= prescaler + SCAN_DIV'(1);
      if (slot_wrap) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      if (frame_wrap) begin
        if (frame_cnt == LAST_FRAME) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
    end
  end

  // Staging buffer and pending flag; display buffer updates only at frame boundaries.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      pending    <= 1'b0;
      stg_hex    <= '0;
      stg_dp     <= '0;
      stg_en     <= '0;
      stg_blink  <= '0;
      disp_hex   <= '0;
      disp_dp    <= '0;
      disp_en    <= '0;
      disp_blink <= '0;
    end else begin
      if (load) begin
        stg_hex   <= hex_in;
        stg_dp    <= dp_in;
        stg_en    <= digit_en;
        stg_blink <= blink_en;
        pending   <= 1'b1;
      end else if (transfer) begin
        pending <= 1'b0;
      end
      if (transfer) begin
        disp_hex   <= stg_hex;
        disp_dp    <= stg_dp;
        disp_en    <= stg_en;
        disp_blink <= stg_blink;
      end
    end
  end

  // Registered pin drive and status pulses.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      an          <= '1;
      seg         <= 7'h7F;
      dp_n        <= 1'b1;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      load_ack    <= transfer;
      frame_start <= frame_wrap;
      if (lit) begin
        an   <= ~(NUM_DIGITS'(1) << idx);
        seg  <= decode(cur_hex);
        dp_n <= ~cur_dp;
      end else begin
        an   <= '1;
        seg  <= 7'h7F;
        dp_n <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Parametrised N-digit seven-segment display controller that replaces ad-hoc per-top SSD scan muxes. It holds a double-buffered frame of hex digits, decimal points and per-digit enable/blink flags, and time-multiplexes them onto active-low anodes and cathodes. It also provides PWM brightness control and tear-free updates at frame boundaries. It sits between game/FSM logic and the board pins (CA..CG, DP, AN*).

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (1..16)
SCAN_DIV, 18, digit slot length = 2^SCAN_DIV board_clk cycles (must be >= BRIGHT_W)
BRIGHT_W, 4, brightness control width
BLINK_FRAMES, 64, frames per blink half-period (>=1)

Ports:
board_clk  in  1  system clock
reset  in  1  reset
hex_in  in  4*NUM_DIGITS  digit i value = hex_in[4i+3:4i]
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
digit_en  in  NUM_DIGITS  1 = digit displayed
blink_en  in  NUM_DIGITS  1 = digit blinks
load  in  1  capture hex_in/dp_in/digit_en/blink_en into staging
brightness  in  BRIGHT_W  PWM duty; 0 = dark
load_ack  out  1  one-cycle pulse when staged data becomes visible
an  out  NUM_DIGITS  anodes, active-low, an[i] = digit i
seg  out  7  cathodes {CA,CB,CC,CD,CE,CF,CG}, active-low
dp_n  out  1  DP cathode, active-low
frame_start  out  1  one-cycle pulse at start of digit 0 slot

Behaviour:
- reset: reset, asynchronous, active-high; clock board_clk. All state is cleared on reset assertion, independent of the clock.
- Reset values: an = all 1, seg = 7'b1111111, dp_n = 1, load_ack = 0, frame_start = 0, prescaler = 0, digit index = 0, frame counter = 0, blink phase = 0, pending = 0, staging and display registers = 0. All digits stay dark until the first transfer.
- Prescaler: SCAN_DIV-bit free-running counter.
  - Its wrap (all 1 -> 0) advances the digit index 0..NUM_DIGITS-1 with modulo wrap.
  - The index wrap NUM_DIGITS-1 -> 0 is the frame boundary.
- Frame boundary actions, on the same edge:
  - frame_start is asserted for the following cycle.
  - If pending = 1: staging is copied to display, pending is cleared, and load_ack pulses for the following cycle.
  - The frame counter increments. On reaching BLINK_FRAMES it resets to 0 and blink phase toggles.
- load:
  - On any edge with load = 1, inputs are written to staging and pending is set.
  - Multiple loads within one frame overwrite staging and produce exactly one load_ack.
  - A load coinciding with a frame boundary edge does not transfer on that edge; staging still gets the new data and pending stays 1 for the next boundary.
- Lit condition for the current digit i: display digit_en[i] = 1, AND NOT (display blink_en[i] AND blink phase = 1), AND prescaler[SCAN_DIV-1 -: BRIGHT_W] < brightness.
  - Maximum brightness yields (2^BRIGHT_W - 1)/2^BRIGHT_W duty.
  - brightness changes take effect immediately (not double-buffered).
- Outputs are registered, one cycle after the prescaler/index state they reflect.
  - When lit: an has only bit i = 0, seg = decode(digit i), dp_n = ~dp[i].
  - When not lit: an = all 1, seg = 7'h7F, dp_n = 1.
- Decode table (seg, active-low) for hex 0-F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- Reset mid-operation: outputs go dark immediately. Pending data is discarded, so no load_ack follows the release. Scan restarts at digit 0 with prescaler = 0.
- Never more than one anode is low in any cycle.

Test Plan:
1. Reset, no load, brightness = 15 -> an stays all 1, seg = 7'h7F, load_ack never pulses; frame_start pulses every NUM_DIGITS*2^SCAN_DIV cycles.
2. NUM_DIGITS = 4, SCAN_DIV = 4, BRIGHT_W = 4, brightness = 15; load hex_in = 16'h1234, digit_en = 4'hF, dp_in = 4'b0001 -> load_ack one cycle after the next boundary.
   - Then an = 1110 (seg 1001100, dp_n 0), 1101 (0000110), 1011 (0010010), 0111 (1001111).
   - Each digit is lit 15 of 16 cycles, with the 16th cycle dark.
3. Same setup, brightness = 0 -> an all 1. brightness = 8 -> each digit lit for 8 cycles of 16.
4. Two loads in one frame (16'h1111, then 16'hABCD) -> a single load_ack; the display shows ABCD and never shows 1111.
5. BLINK_FRAMES = 2, blink_en = 4'b0010 -> digit 1 is dark in frames 2, 3, 6, 7, ... and lit in frames 0, 1, 4, 5; digits 0, 2, 3 are unaffected.
6. load, then assert reset mid-slot before the boundary -> an = all 1 within the same cycle (async); after release no load_ack, all digits dark, and the index restarts at 0.
